// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit in front of a word-addressed memory that
// has no byte enables. SB/SH use read-modify-write, loads are lane-extracted
// and extended, and illegal or misaligned requests return an error response.
// Optional feature macro: LSU_BOUND_CHECK_EN. When defined, word indices at
// or above MEM_WORDS are rejected. When undefined, the index wraps modulo
// 2**ADDR_WIDTH.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_WORDS  = 256
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    // Byte-address bits kept after accept: word index plus the lane offset.
    localparam int unsigned AW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_RSP,
        ST_WR,
        ST_RD,
        ST_MRG,
        ERR
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;

    logic          req_err_c;
    logic [31:0]   shifted_c;
    logic [31:0]   load_c;
    logic [31:0]   merged_c;

`ifndef LSU_BOUND_CHECK_EN
    // Upper address bits are deliberately ignored in the wrapping build.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];
`endif

    // Request legality: funct3 code, store width, alignment and optional bound.
    always_comb begin
        req_err_c = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
                 || (req_write && req_funct3[2])
                 || ((req_funct3[1:0] == 2'd1) && req_addr[0])
                 || ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00));
`ifdef LSU_BOUND_CHECK_EN
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err_c = 1'b1;
        end
`endif
    end

    // Load path: shift the addressed lane down, then sign or zero extend.
    always_comb begin
        shifted_c = mem_read_data >> {addr_q[1:0], 3'b000};
        case (funct3_q[1:0])
            2'd0:    load_c = {{24{~funct3_q[2] & shifted_c[7]}},  shifted_c[7:0]};
            2'd1:    load_c = {{16{~funct3_q[2] & shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = mem_read_data;
        endcase
    end

    // Sub-word store merge: replace the addressed lane of the old word.
    always_comb begin
        merged_c = mem_read_data;
        if (funct3_q[0]) begin
            merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Control FSM with request capture and registered response.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            addr_q    <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[AW-1:0];
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (req_err_c) begin
                            state <= ERR;
                        end else if (!req_write) begin
                            state <= LD_RD;
                        end else if (req_funct3 == 3'd2) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                LD_RD: begin
                    state <= LD_RSP;
                end
                LD_RSP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= load_c;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                ST_RD: begin
                    state <= ST_MRG;
                end
                ST_WR, ST_MRG: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port decoded from state. Strobes are masked while reset is held,
    // so a reset landing on the merge edge never commits a partial store.
    always_comb begin
        req_ready      = (state == IDLE);
        mem_read       = rst && ((state == LD_RD) || (state == ST_RD));
        mem_write      = rst && ((state == ST_WR) || (state == ST_MRG));
        mem_address    = '0;
        mem_write_data = '0;
        if ((state != IDLE) && (state != ERR)) begin
            mem_address = 32'(addr_q[AW-1:2]);
        end
        if (state == ST_WR) begin
            mem_write_data = wdata_q;
        end else if (state == ST_MRG) begin
            mem_write_data = merged_c;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic checked against a byte-level reference memory model.
module tb_load_store_unit;

    localparam int unsigned WORDS = 256;

    logic        clock = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    logic [31:0] dut_mem [WORDS];
    logic [31:0] ref_mem [WORDS];

    int rd_cnt    = 0;
    int wr_cnt    = 0;
    int clash_cnt = 0;
    int n_checks  = 0;
    int n_pass    = 0;

    load_store_unit #(.ADDR_WIDTH(8), .MEM_WORDS(256)) dut (
        .clock          (clock),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_funct3     (req_funct3),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;

    // Word memory with registered read data, plus strobe counters.
    always @(posedge clock) begin
        if (mem_write) dut_mem[mem_address[7:0]] <= mem_write_data;
        if (mem_read)  mem_read_data <= dut_mem[mem_address[7:0]];
        if (mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read && mem_write) clash_cnt <= clash_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: RV32I access semantics on a plain word array.
    task automatic model(input logic [31:0] a, input logic [2:0] f, input logic w,
                         input logic [31:0] wd, output logic [31:0] d, output logic e,
                         output int lat, output int nrd, output int nwr);
        int size;
        int idx;
        int sh;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        case (f[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            default: size = 4;
        endcase
        e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f >= 3'd4)
            || ((int'(a[1:0]) % size) != 0);
`ifdef LSU_BOUND_CHECK_EN
        if ((a >> 2) >= WORDS) e = 1'b1;
`endif
        idx  = int'((a >> 2) % WORDS);
        sh   = 8 * int'(a[1:0]);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        word = ref_mem[idx];
        d    = '0;
        nrd  = 0;
        nwr  = 0;
        if (e) begin
            lat = 1;
        end else if (!w) begin
            val = (word >> sh) & mask;
            if (f < 3'd4 && size < 4 && val[8 * size - 1]) val = val | ~mask;
            d   = val;
            lat = 2;
            nrd = 1;
        end else begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            nwr = 1;
            nrd = (size < 4) ? 1 : 0;
            lat = (size < 4) ? 2 : 1;
        end
    endtask

    // Issue one request from a negedge and return at the negedge showing rsp_valid.
    task automatic do_req(input logic [31:0] a, input logic [2:0] f, input logic w,
                          input logic [31:0] wd, output logic [31:0] d, output logic e);
        logic [31:0] exp_d;
        logic        exp_e;
        int exp_lat, exp_rd, exp_wr, lat, rd0, wr0, waited, idx;
        string tg;
        model(a, f, w, wd, exp_d, exp_e, exp_lat, exp_rd, exp_wr);
        idx = int'((a >> 2) % WORDS);
        tg  = $sformatf("a=%08h f=%0d w=%0b", a, f, w);
        waited = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        check_eq({"req_ready ", tg}, 32'(req_ready), 32'd1);
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f;
        req_write  = w;
        req_wdata  = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (rsp_valid === 1'b1) lat = k;
        end
        check_eq({"latency ", tg}, 32'(lat), 32'(exp_lat));
        check_eq({"rsp_data ", tg}, rsp_data, exp_d);
        check_eq({"rsp_err ", tg}, 32'(rsp_err), 32'(exp_e));
        check_eq({"mem_reads ", tg}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check_eq({"mem_writes ", tg}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (w && !exp_e) check_eq({"mem_word ", tg}, dut_mem[idx], ref_mem[idx]);
        d = rsp_data;
        e = rsp_err;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] a;
        logic [2:0]  f;
        logic        w;
        int          bad;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_write  = 1'b0;
        req_wdata  = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst rsp_data", rsp_data, 32'd0);
        check_eq("rst rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst req_ready", 32'(req_ready), 32'd1);
        check_eq("rst mem_read", 32'(mem_read), 32'd0);
        check_eq("rst mem_write", 32'(mem_write), 32'd0);
        check_eq("rst mem_address", mem_address, 32'd0);
        check_eq("rst mem_write_data", mem_write_data, 32'd0);
        rst = 1'b1;
        @(negedge clock);

        // Preload every word through SW, then fix the directed words.
        for (int i = 0; i < int'(WORDS); i++) do_req(32'(i * 4), 3'd2, 1'b1, $urandom, d, e);
        do_req(32'h0, 3'd2, 1'b1, 32'h0BAD_F00D, d, e);
        do_req(32'h4, 3'd2, 1'b1, 32'h8081_82F3, d, e);
        do_req(32'h8, 3'd2, 1'b1, 32'h1111_1111, d, e);

        // Sub-word loads with sign and zero extension
        do_req(32'h7, 3'd0, 1'b0, 32'h0, d, e);
        check_eq("lb 0x7", d, 32'hFFFF_FF80);
        do_req(32'h7, 3'd4, 1'b0, 32'h0, d, e);
        check_eq("lbu 0x7", d, 32'h0000_0080);
        do_req(32'h4, 3'd1, 1'b0, 32'h0, d, e);
        check_eq("lh 0x4", d, 32'hFFFF_82F3);
        do_req(32'h6, 3'd5, 1'b0, 32'h0, d, e);
        check_eq("lhu 0x6", d, 32'h0000_8081);

        // SB read-modify-write
        do_req(32'h9, 3'd0, 1'b1, 32'h0000_00AB, d, e);
        check_eq("sb word2", dut_mem[2], 32'h1111_AB11);

        // SW then back-to-back LW accepted in the response cycle
        do_req(32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF, d, e);
        check_eq("sw word4", dut_mem[4], 32'hDEAD_BEEF);
        do_req(32'h10, 3'd2, 1'b0, 32'h0, d, e);
        check_eq("lw b2b 0x10", d, 32'hDEAD_BEEF);

        // Error responses
        do_req(32'h2, 3'd2, 1'b0, 32'h0, d, e);
        check_eq("lw 0x2 err", 32'(e), 32'd1);
        do_req(32'h3, 3'd1, 1'b1, 32'h1234, d, e);
        check_eq("sh 0x3 err", 32'(e), 32'd1);
        do_req(32'h0, 3'd6, 1'b0, 32'h0, d, e);
        check_eq("funct3 6 err", 32'(e), 32'd1);
        do_req(32'h400, 3'd2, 1'b0, 32'h0, d, e);
`ifdef LSU_BOUND_CHECK_EN
        check_eq("lw 0x400 bound err", 32'(e), 32'd1);
`else
        check_eq("lw 0x400 wraps", d, 32'h0BAD_F00D);
`endif

        // Reset during the merge cycle of an SH must not write or respond.
        req_valid  = 1'b1;
        req_addr   = 32'h8;
        req_funct3 = 3'd1;
        req_write  = 1'b1;
        req_wdata  = 32'h0000_5555;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        bad = wr_cnt;
        @(posedge clock);
        @(negedge clock);
        check_eq("rmw rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rmw rst req_ready", 32'(req_ready), 32'd1);
        check_eq("rmw rst writes", 32'(wr_cnt - bad), 32'd0);
        check_eq("rmw rst word2", dut_mem[2], 32'h1111_AB11);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rmw rst no late rsp", 32'(rsp_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            do_req(a, f, w, $urandom, d, e);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clock);
                check_eq("rsp_valid one cycle", 32'(rsp_valid), 32'd0);
            end
        end

        bad = 0;
        for (int i = 0; i < int'(WORDS); i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        check_eq("final memory mismatches", 32'(bad), 32'd0);
        check_eq("read/write strobe clash", 32'(clash_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
